lcd_nios2_qsys_0_ocimem_arbiter: RTL and testbench

Arbitrates the single-port 256x32 on-chip debug memory (OCI RAM) between the CPU debug slave (Avalon-MM) and the JTAG debug path. The JTAG path arrives as `take_action_ocimem_*` pulses and `jdo` from the debug module's sysclk side. The block serialises both requesters onto one RAM port, auto-increments the JTAG address, and returns JTAG read data in `MonDReg`. It sits between the JTAG debug module wrapper, the CPU debug slave decode and the OCI RAM instance.

---
 rtl/lcd_nios2_qsys_0_ocimem_pkg.sv | 29 ++
 rtl/lcd_nios2_qsys_0_ocimem_jtag_req.sv | 88 ++++++++
 rtl/lcd_nios2_qsys_0_ocimem_arbiter.sv | 151 +++++++++++++++
 tb/tb_lcd_nios2_qsys_0_ocimem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_nios2_qsys_0_ocimem_pkg.sv
//=============================================================================
// Module : lcd_nios2_qsys_0_ocimem_pkg
// Brief  : Shared types and jdo field positions for the OCI RAM arbiter.
// Rev    : 1.0
//=============================================================================
`default_nettype none

package lcd_nios2_qsys_0_ocimem_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   // jdo shift-register layout; the address field overlaps the write data
   localparam int JDO_W    = 38;
   localparam int READ_BIT = 35;
   localparam int ADDR_HI  = 24;
   localparam int ADDR_LO  = 17;
   localparam int WDATA_HI = 34;
   localparam int WDATA_LO = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_RD  = 2'd1,
      JTAG_RD = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/lcd_nios2_qsys_0_ocimem_jtag_req.sv
//=============================================================================
// Module : lcd_nios2_qsys_0_ocimem_jtag_req
// Brief  : JTAG pending request register, auto-increment address, overrun flag.
// Rev    : 1.0
//=============================================================================
`default_nettype none

module lcd_nios2_qsys_0_ocimem_jtag_req
   import lcd_nios2_qsys_0_ocimem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_take_action_ocimem_a,
   input  logic              i_take_no_action_ocimem_a,
   input  logic              i_take_action_ocimem_b,
   input  logic [JDO_W-1:0]  i_jdo,
   input  logic              i_grant,
   output logic              o_pend_valid,
   output logic              o_pend_write,
   output logic [DATA_W-1:0] o_pend_data,
   output logic [ADDR_W-1:0] o_jaddr,
   output logic              o_overrun
);

   logic              r_valid;
   logic              r_write;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_jaddr;
   logic              r_overrun;

   logic              w_new_req;
   logic              w_overrun_nxt;
   logic              w_unused_jdo;

   // action_a only queues a request when its read bit is set
   assign w_new_req = (i_take_action_ocimem_a & i_jdo[READ_BIT])
                    | i_take_no_action_ocimem_a
                    | i_take_action_ocimem_b;

   // action_a wipes the sticky flag first, then may raise it again itself
   always_comb begin
      w_overrun_nxt = i_take_action_ocimem_a ? 1'b0 : r_overrun;
      if (w_new_req && r_valid && !i_grant) begin
         w_overrun_nxt = 1'b1;
      end
   end

   assign w_unused_jdo = ^{i_jdo[JDO_W-1:READ_BIT+1], i_jdo[WDATA_LO-1:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid   <= 1'b0;
         r_write   <= 1'b0;
         r_data    <= '0;
         r_jaddr   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_new_req) begin
            r_valid <= 1'b1;
            r_write <= i_take_action_ocimem_b;
            r_data  <= i_jdo[WDATA_HI:WDATA_LO];
         end else if (i_grant) begin
            r_valid <= 1'b0;
         end

         r_overrun <= w_overrun_nxt;

         // a fresh address load overrides the post-access increment
         if (i_take_action_ocimem_a) begin
            r_jaddr <= i_jdo[ADDR_HI:ADDR_LO];
         end else if (i_grant) begin
            r_jaddr <= r_jaddr + ADDR_W'(1);
         end
      end
   end

   assign o_pend_valid = r_valid;
   assign o_pend_write = r_write;
   assign o_pend_data  = r_data;
   assign o_jaddr      = r_jaddr;
   assign o_overrun    = r_overrun;

endmodule

`default_nettype wire

// File: rtl/lcd_nios2_qsys_0_ocimem_arbiter.sv
//=============================================================================
// Module : lcd_nios2_qsys_0_ocimem_arbiter
// Brief  : Serialises CPU debug-slave and JTAG accesses onto the OCI RAM port.
// Rev    : 1.0
//=============================================================================
`default_nettype none

module lcd_nios2_qsys_0_ocimem_arbiter
   import lcd_nios2_qsys_0_ocimem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [JDO_W-1:0]  jdo,
   input  logic [ADDR_W-1:0] av_address,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [DATA_W-1:0] av_writedata,
   input  logic [3:0]        av_byteenable,
   output logic [DATA_W-1:0] av_readdata,
   output logic              av_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   output logic [3:0]        ram_byteenable,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] MonDReg,
   output logic              jtag_busy,
   output logic              jtag_overrun
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last_jtag;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_mon_dreg;

   logic              w_cpu_req;
   logic              w_grant_jtag;
   logic              w_grant_cpu;
   logic              w_pend_valid;
   logic              w_pend_write;
   logic [DATA_W-1:0] w_pend_data;
   logic [ADDR_W-1:0] w_jaddr;

   lcd_nios2_qsys_0_ocimem_jtag_req #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_jtag_req (
      .clk                       (clk),
      .reset_n                   (reset_n),
      .i_take_action_ocimem_a    (take_action_ocimem_a),
      .i_take_no_action_ocimem_a (take_no_action_ocimem_a),
      .i_take_action_ocimem_b    (take_action_ocimem_b),
      .i_jdo                     (jdo),
      .i_grant                   (w_grant_jtag),
      .o_pend_valid              (w_pend_valid),
      .o_pend_write              (w_pend_write),
      .o_pend_data               (w_pend_data),
      .o_jaddr                   (w_jaddr),
      .o_overrun                 (jtag_overrun)
   );

   assign w_cpu_req = av_read | av_write;

   // Grants are suppressed while reset is held so the CPU only ever sees
   // waitrequest=1 and the RAM sees no write strobe during reset.
   always_comb begin
      w_state_nxt    = r_state;
      w_grant_jtag   = 1'b0;
      w_grant_cpu    = 1'b0;
      ram_addr       = r_ram_addr;
      ram_wr         = 1'b0;
      ram_byteenable = 4'hF;
      ram_wdata      = av_writedata;
      av_waitrequest = 1'b1;
      av_readdata    = '0;

      case (r_state)
         IDLE: begin
            if (reset_n) begin
               // JTAG wins unless it also won last time and the CPU is waiting
               if (w_pend_valid && !(r_last_jtag && w_cpu_req)) begin
                  w_grant_jtag = 1'b1;
                  ram_addr     = w_jaddr;
                  if (w_pend_write) begin
                     ram_wr    = 1'b1;
                     ram_wdata = w_pend_data;
                  end else begin
                     w_state_nxt = JTAG_RD;
                  end
               end else if (w_cpu_req) begin
                  w_grant_cpu = 1'b1;
                  ram_addr    = av_address;
                  if (av_write) begin
                     ram_wr         = 1'b1;
                     ram_byteenable = av_byteenable;
                     av_waitrequest = 1'b0;
                  end else begin
                     w_state_nxt = CPU_RD;
                  end
               end
            end
         end
         CPU_RD: begin
            av_waitrequest = 1'b0;
            av_readdata    = ram_rdata;
            w_state_nxt    = IDLE;
         end
         JTAG_RD: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_last_jtag <= 1'b0;
         r_ram_addr  <= '0;
         r_mon_dreg  <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_grant_jtag || w_grant_cpu) begin
            r_ram_addr  <= ram_addr;
            r_last_jtag <= w_grant_jtag;
         end

         if (w_grant_jtag && w_pend_write) begin
            r_mon_dreg <= w_pend_data;
         end else if (r_state == JTAG_RD) begin
            r_mon_dreg <= ram_rdata;
         end
      end
   end

   assign MonDReg   = r_mon_dreg;
   assign jtag_busy = w_pend_valid | (r_state == JTAG_RD);

endmodule

`default_nettype wire

// File: tb/tb_lcd_nios2_qsys_0_ocimem_arbiter.sv
//=============================================================================
// Module : tb_lcd_nios2_qsys_0_ocimem_arbiter
// Brief  : Self-checking bench with RAM model and transaction-level reference.
// Rev    : 1.0
//=============================================================================
`default_nettype none

module tb_lcd_nios2_qsys_0_ocimem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
   logic [37:0] jdo;
   logic [7:0]  av_address;
   logic        av_read, av_write;
   logic [31:0] av_writedata;
   logic [3:0]  av_byteenable;
   logic [31:0] av_readdata;
   logic        av_waitrequest;
   logic [7:0]  ram_addr;
   logic        ram_wr;
   logic [3:0]  ram_byteenable;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] MonDReg;
   logic        jtag_busy, jtag_overrun;

   int n_checks;
   int n_fail;

   logic [31:0] mem [0:255];
   logic        mem_init_done = 1'b0;
   logic [31:0] exp_mem [0:255];

   lcd_nios2_qsys_0_ocimem_arbiter dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .jdo                     (jdo),
      .av_address              (av_address),
      .av_read                 (av_read),
      .av_write                (av_write),
      .av_writedata            (av_writedata),
      .av_byteenable           (av_byteenable),
      .av_readdata             (av_readdata),
      .av_waitrequest          (av_waitrequest),
      .ram_addr                (ram_addr),
      .ram_wr                  (ram_wr),
      .ram_byteenable          (ram_byteenable),
      .ram_wdata               (ram_wdata),
      .ram_rdata               (ram_rdata),
      .MonDReg                 (MonDReg),
      .jtag_busy               (jtag_busy),
      .jtag_overrun            (jtag_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [7:0] a);
      return {a, ~a, a ^ 8'h5A, 8'hC3};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] a);
      logic [37:0] j;
      j = '0; j[35] = rd; j[24:17] = a;
      return j;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] d);
      logic [37:0] j;
      j = '0; j[34:3] = d;
      return j;
   endfunction

   // single-port RAM, 1-cycle read latency, byte-enabled writes
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
         mem_init_done <= 1'b1;
      end else if (ram_wr) begin
         for (int b = 0; b < 4; b++)
            if (ram_byteenable[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (av_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_waitreq: got %b want 1", av_waitrequest); end
      n_checks++; if (ram_wr !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr); end
      n_checks++; if (ram_addr !== 8'h00) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 00", ram_addr); end
      n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
      n_checks++; if (av_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h want 0", av_readdata); end
      n_checks++; if ({jtag_busy, jtag_overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {jtag_busy, jtag_overrun}); end
      reset_n = 1'b1;
   endtask

   task automatic test_jtag_write_read;
      tick; take_action_ocimem_a = 1'b1; jdo = jdo_a(1'b0, 8'h10);
      tick; take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b1; jdo = jdo_b(32'hDEADBEEF);
      @(negedge clk);
      n_checks++; if (jtag_busy !== 1'b0) begin n_fail++; $display("FAIL addr_only_busy: got %b want 0", jtag_busy); end
      tick; take_action_ocimem_b = 1'b0; take_action_ocimem_a = 1'b1; jdo = jdo_a(1'b1, 8'h10);
      @(negedge clk);
      n_checks++; if ({ram_wr, ram_addr, ram_byteenable, ram_wdata} !== {1'b1, 8'h10, 4'hF, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL jwr_grant: got wr=%b a=%h be=%h d=%h want 1 10 f deadbeef", ram_wr, ram_addr, ram_byteenable, ram_wdata); end
      exp_mem[8'h10] = 32'hDEADBEEF;
      tick; take_action_ocimem_a = 1'b0;
      @(negedge clk);
      n_checks++; if ({jtag_busy, ram_wr, ram_addr} !== {1'b1, 1'b0, 8'h10}) begin
         n_fail++; $display("FAIL jrd_grant: got busy=%b wr=%b a=%h want 1 0 10", jtag_busy, ram_wr, ram_addr); end
      tick; @(negedge clk);
      n_checks++; if (jtag_busy !== 1'b1) begin n_fail++; $display("FAIL jrd_busy_p2: got %b want 1", jtag_busy); end
      tick; @(negedge clk);
      n_checks++; if (MonDReg !== 32'hDEADBEEF) begin n_fail++; $display("FAIL jrd_mondreg: got %h want deadbeef", MonDReg); end
      n_checks++; if ({jtag_busy, jtag_overrun} !== 2'b00) begin n_fail++; $display("FAIL jrd_flags_p3: got %b want 00", {jtag_busy, jtag_overrun}); end
      n_checks++; if (mem[8'h10] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL jwr_ram: got %h want deadbeef", mem[8'h10]); end
      tick; take_no_action_ocimem_a = 1'b1;
      tick; take_no_action_ocimem_a = 1'b0;
      @(negedge clk);
      n_checks++; if ({ram_wr, ram_addr} !== {1'b0, 8'h11}) begin n_fail++; $display("FAIL jaddr_incr: got wr=%b a=%h want 0 11", ram_wr, ram_addr); end
      tick; tick; @(negedge clk);
      n_checks++; if (MonDReg !== exp_mem[8'h11]) begin n_fail++; $display("FAIL jrd_next: got %h want %h", MonDReg, exp_mem[8'h11]); end
   endtask

   task automatic test_wrap;
      tick; take_action_ocimem_a = 1'b1; jdo = jdo_a(1'b0, 8'hFF);
      tick; take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b1; jdo = jdo_b(32'd1);
      tick; jdo = jdo_b(32'd2);
      @(negedge clk);
      n_checks++; if ({ram_wr, ram_addr} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL wrap_wr1: got wr=%b a=%h want 1 ff", ram_wr, ram_addr); end
      tick; take_action_ocimem_b = 1'b0;
      @(negedge clk);
      n_checks++; if ({ram_wr, ram_addr, jtag_overrun} !== {1'b1, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL wrap_wr2: got wr=%b a=%h ovr=%b want 1 00 0", ram_wr, ram_addr, jtag_overrun); end
      exp_mem[8'hFF] = 32'd1; exp_mem[8'h00] = 32'd2;
      tick; take_no_action_ocimem_a = 1'b1;
      tick; take_no_action_ocimem_a = 1'b0;
      @(negedge clk);
      n_checks++; if ({ram_wr, ram_addr} !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL wrap_jaddr: got wr=%b a=%h want 0 01", ram_wr, ram_addr); end
      tick; tick; @(negedge clk);
      n_checks++; if ({mem[8'hFF], mem[8'h00]} !== {32'd1, 32'd2}) begin
         n_fail++; $display("FAIL wrap_ram: got %h %h want 1 2", mem[8'hFF], mem[8'h00]); end
      n_checks++; if (MonDReg !== exp_mem[8'h01]) begin n_fail++; $display("FAIL wrap_rd: got %h want %h", MonDReg, exp_mem[8'h01]); end
   endtask

   task automatic test_cpu_byte_write;
      tick; av_write = 1'b1; av_address = 8'h05; av_writedata = 32'h11223344; av_byteenable = 4'hF;
      @(negedge clk);
      n_checks++; if ({av_waitrequest, ram_wr, ram_byteenable} !== {1'b0, 1'b1, 4'hF}) begin
         n_fail++; $display("FAIL cpu_wr_full: got wreq=%b wr=%b be=%h want 0 1 f", av_waitrequest, ram_wr, ram_byteenable); end
      tick; av_writedata = 32'h0000AB00; av_byteenable = 4'b0010;
      @(negedge clk);
      n_checks++; if ({av_waitrequest, ram_wr, ram_addr, ram_byteenable} !== {1'b0, 1'b1, 8'h05, 4'b0010}) begin
         n_fail++; $display("FAIL cpu_wr_byte: got wreq=%b wr=%b a=%h be=%h want 0 1 05 2", av_waitrequest, ram_wr, ram_addr, ram_byteenable); end
      tick; av_write = 1'b0;
      @(negedge clk);
      n_checks++; if ({av_waitrequest, ram_wr, ram_addr} !== {1'b1, 1'b0, 8'h05}) begin
         n_fail++; $display("FAIL cpu_idle: got wreq=%b wr=%b a=%h want 1 0 05", av_waitrequest, ram_wr, ram_addr); end
      n_checks++; if (mem[8'h05] !== 32'h1122AB44) begin n_fail++; $display("FAIL cpu_byte_ram: got %h want 1122ab44", mem[8'h05]); end
      exp_mem[8'h05] = 32'h1122AB44;
      tick; av_read = 1'b1;
      @(negedge clk);
      n_checks++; if (av_waitrequest !== 1'b1) begin n_fail++; $display("FAIL cpu_rd_c0: got %b want 1", av_waitrequest); end
      tick; @(negedge clk);
      n_checks++; if ({av_waitrequest, av_readdata} !== {1'b0, 32'h1122AB44}) begin
         n_fail++; $display("FAIL cpu_rd_c1: got wreq=%b d=%h want 0 1122ab44", av_waitrequest, av_readdata); end
      tick; av_read = 1'b0;
   endtask

   task automatic test_contention;
      tick; take_action_ocimem_a = 1'b1; jdo = jdo_a(1'b0, 8'h30);
      tick; take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b1; jdo = jdo_b(32'hC0DE0000);
      tick; jdo = jdo_b(32'hC0DE0001); av_read = 1'b1; av_address = 8'h20;
      @(negedge clk);
      n_checks++; if ({ram_wr, ram_addr, av_waitrequest} !== {1'b1, 8'h30, 1'b1}) begin
         n_fail++; $display("FAIL cont_c1_jtag: got wr=%b a=%h wreq=%b want 1 30 1", ram_wr, ram_addr, av_waitrequest); end
      tick; jdo = jdo_b(32'hC0DE0002);
      @(negedge clk);
      n_checks++; if ({ram_wr, ram_addr, av_waitrequest, jtag_overrun} !== {1'b0, 8'h20, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL cont_c2_cpu: got wr=%b a=%h wreq=%b ovr=%b want 0 20 1 0", ram_wr, ram_addr, av_waitrequest, jtag_overrun); end
      tick; jdo = jdo_b(32'hC0DE0003);
      @(negedge clk);
      n_checks++; if ({av_waitrequest, av_readdata} !== {1'b0, exp_mem[8'h20]}) begin
         n_fail++; $display("FAIL cont_c3_rd: got wreq=%b d=%h want 0 %h", av_waitrequest, av_readdata, exp_mem[8'h20]); end
      n_checks++; if (jtag_overrun !== 1'b1) begin n_fail++; $display("FAIL cont_overrun: got %b want 1", jtag_overrun); end
      tick; take_action_ocimem_b = 1'b0; av_read = 1'b0;
      @(negedge clk);
      n_checks++; if ({ram_wr, ram_addr, ram_wdata} !== {1'b1, 8'h31, 32'hC0DE0003}) begin
         n_fail++; $display("FAIL cont_c4_jtag: got wr=%b a=%h d=%h want 1 31 c0de0003", ram_wr, ram_addr, ram_wdata); end
      exp_mem[8'h30] = 32'hC0DE0000; exp_mem[8'h31] = 32'hC0DE0003;
      tick; @(negedge clk);
      n_checks++; if ({mem[8'h30], mem[8'h31], jtag_busy} !== {32'hC0DE0000, 32'hC0DE0003, 1'b0}) begin
         n_fail++; $display("FAIL cont_ram: got %h %h busy=%b want c0de0000 c0de0003 0", mem[8'h30], mem[8'h31], jtag_busy); end
      tick; take_action_ocimem_a = 1'b1; jdo = jdo_a(1'b0, 8'h00);
      tick; take_action_ocimem_a = 1'b0;
      @(negedge clk);
      n_checks++; if (jtag_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", jtag_overrun); end
   endtask

   task automatic test_reset_mid_read;
      bit done;
      tick; av_read = 1'b1; av_address = 8'h05; take_no_action_ocimem_a = 1'b1;
      tick; take_no_action_ocimem_a = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_checks++; if ({av_waitrequest, jtag_busy, ram_wr, MonDReg, av_readdata} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0}) begin
         n_fail++; $display("FAIL rst_mid: got wreq=%b busy=%b wr=%b mon=%h rd=%h want 1 0 0 0 0", av_waitrequest, jtag_busy, ram_wr, MonDReg, av_readdata); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      done = 1'b0;
      for (int n = 0; n < 5 && !done; n++) begin
         tick; @(negedge clk);
         if (av_waitrequest === 1'b0) done = 1'b1;
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_resume_timeout: got done=%b want 1", done); end
      n_checks++; if (av_readdata !== 32'h1122AB44) begin n_fail++; $display("FAIL rst_resume_data: got %h want 1122ab44", av_readdata); end
      tick; av_read = 1'b0; take_no_action_ocimem_a = 1'b1;
      tick; take_no_action_ocimem_a = 1'b0;
      @(negedge clk);
      n_checks++; if (ram_addr !== 8'h00) begin n_fail++; $display("FAIL rst_jaddr: got %h want 00", ram_addr); end
      tick; tick; @(negedge clk);
      n_checks++; if (MonDReg !== exp_mem[8'h00]) begin n_fail++; $display("FAIL rst_jrd: got %h want %h", MonDReg, exp_mem[8'h00]); end
   endtask

   // JTAG traffic confined to the low quarter, spaced so every access retires
   task automatic jtag_random;
      logic [7:0]  ja;
      logic [31:0] d, exp_md;
      int          kind;
      tick; ja = 8'($urandom_range(0, 31)); take_action_ocimem_a = 1'b1; jdo = jdo_a(1'b0, ja);
      tick; take_action_ocimem_a = 1'b0;
      for (int i = 0; i < 30; i++) begin
         kind = int'($urandom_range(0, 2));
         tick;
         if (kind == 0) begin
            d = $urandom; take_action_ocimem_b = 1'b1; jdo = jdo_b(d);
            exp_mem[ja] = d; exp_md = d;
         end else if (kind == 1) begin
            take_no_action_ocimem_a = 1'b1; exp_md = exp_mem[ja];
         end else begin
            ja = 8'($urandom_range(0, 31)); take_action_ocimem_a = 1'b1; jdo = jdo_a(1'b1, ja);
            exp_md = exp_mem[ja];
         end
         ja = ja + 8'd1;
         tick; take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
         repeat (5) tick;
         @(negedge clk);
         n_checks++; if ({MonDReg, jtag_busy, jtag_overrun} !== {exp_md, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rand_jtag[%0d]: got mon=%h busy=%b ovr=%b want %h 0 0", i, MonDReg, jtag_busy, jtag_overrun, exp_md); end
      end
   endtask

   // CPU traffic confined to the upper half
   task automatic cpu_random;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      bit          is_wr, done;
      int          lat, max_lat;
      for (int i = 0; i < 40; i++) begin
         tick;
         repeat ($urandom_range(0, 2)) tick;
         a = 8'h80 | 8'($urandom_range(0, 127)); d = $urandom; be = 4'($urandom_range(0, 15));
         is_wr = bit'($urandom_range(0, 1));
         av_address = a; av_writedata = d; av_byteenable = be;
         av_write = is_wr; av_read = !is_wr;
         done = 1'b0; lat = 0;
         for (int n = 0; n < 6 && !done; n++) begin
            @(negedge clk);
            if (av_waitrequest === 1'b0) begin
               done = 1'b1; lat = n;
               if (is_wr) exp_mem[a] = merge(exp_mem[a], d, be);
               else begin
                  n_checks++; if (av_readdata !== exp_mem[a]) begin
                     n_fail++; $display("FAIL rand_cpu_rd[%0d]: got %h want %h at %h", i, av_readdata, exp_mem[a], a); end
               end
            end else tick;
         end
         max_lat = is_wr ? 2 : 3;
         n_checks++; if (!done || lat > max_lat) begin
            n_fail++; $display("FAIL rand_cpu_lat[%0d]: got done=%b lat=%0d want done=1 lat<=%0d", i, done, lat, max_lat); end
         tick; av_read = 1'b0; av_write = 1'b0;
      end
   endtask

   task automatic test_random;
      fork
         jtag_random();
         cpu_random();
      join
      repeat (4) tick;
      for (int a = 0; a < 256; a++) begin
         if (a < 8'h40 || a >= 8'h80) begin
            n_checks++; if (mem[a] !== exp_mem[a]) begin n_fail++; $display("FAIL rand_ram[%0h]: got %h want %h", a, mem[a], exp_mem[a]); end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
      jdo = '0; av_address = '0; av_read = 1'b0; av_write = 1'b0;
      av_writedata = '0; av_byteenable = '0;
      n_checks = 0; n_fail = 0;
      for (int i = 0; i < 256; i++) exp_mem[i] = pat(8'(i));
      test_reset();
      test_jtag_write_read();
      test_wrap();
      test_cpu_byte_write();
      test_contention();
      test_reset_mid_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire
